// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one pipelined bin_to_gray converter among NREQ requesters.
// Each issued word carries its requester ID down a tag pipe that matches the converter latency.
module gray_conv_arbiter #(
  parameter int NBIT = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*NBIT-1:0] i_req_data,
  input  logic                 i_hold,
  output logic [NREQ-1:0]      o_ack,
  output logic [NBIT-1:0]      o_conv_bin,
  output logic                 o_conv_vld,
  input  logic [NBIT-1:0]      i_conv_gray,
  output logic                 o_rsp_valid,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [NBIT-1:0]      o_rsp_data,
  output logic                 o_busy
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NBIT-1:0] conv_bin_q, conv_bin_d;
  logic            conv_vld_q, conv_vld_d;
  logic [IDW-1:0]  conv_id_q, conv_id_d;
  logic [LAT-1:0]  tag_vld_q, tag_vld_d;
  logic [IDW-1:0]  tag_id_q [LAT];
  logic [IDW-1:0]  tag_id_d [LAT];
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [NBIT-1:0] rsp_data_q, rsp_data_d;

  logic [NBIT-1:0] req_word [NREQ];
  logic [NREQ-1:0] elig;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic [IDW:0]    idx_w;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_word[k] = i_req_data[k*NBIT +: NBIT];
    end
  end

  // A requester acked last edge has not yet refreshed its data, so it sits out one cycle.
  always_comb begin
    elig      = i_req & ~ack_q;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx_w     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_w = {1'b0, ptr_q} + (IDW+1)'(i);
      if (idx_w >= (IDW+1)'(NREQ)) begin
        idx_w = idx_w - (IDW+1)'(NREQ);
      end
      if (!grant_vld && elig[idx_w[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx_w[IDW-1:0];
      end
    end
    if (i_hold) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    ack_d      = '0;
    conv_bin_d = conv_bin_q;
    conv_vld_d = 1'b0;
    conv_id_d  = conv_id_q;
    if (grant_vld) begin
      ptr_d           = grant_id;
      ack_d[grant_id] = 1'b1;
      conv_bin_d      = req_word[grant_id];
      conv_vld_d      = 1'b1;
      conv_id_d       = grant_id;
    end
  end

  // Tag stage k lines up with the converter output k+1 cycles after o_conv_bin.
  always_comb begin
    tag_vld_d = '0;
    for (int k = 0; k < LAT; k++) begin
      tag_id_d[k] = '0;
    end
    tag_vld_d[0] = conv_vld_q;
    tag_id_d[0]  = conv_id_q;
    for (int k = 1; k < LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
    rsp_valid_d = tag_vld_q[LAT-1];
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[LAT-1]) begin
      rsp_id_d   = tag_id_q[LAT-1];
      rsp_data_d = i_conv_gray;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ptr_q       <= IDW'(NREQ-1);
      ack_q       <= '0;
      conv_bin_q  <= '0;
      conv_vld_q  <= 1'b0;
      conv_id_q   <= '0;
      tag_vld_q   <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_id_q[k] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      conv_bin_q  <= conv_bin_d;
      conv_vld_q  <= conv_vld_d;
      conv_id_q   <= conv_id_d;
      tag_vld_q   <= tag_vld_d;
      for (int k = 0; k < LAT; k++) begin
        tag_id_q[k] <= tag_id_d[k];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_conv_bin  = conv_bin_q;
  assign o_conv_vld  = conv_vld_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = (|tag_vld_q) | rsp_valid_q;

endmodule
